// File: rtl/muladd_dot_seq.sv
// muladd_dot_seq: accumulates signed 8x8 products through a MULADDA primitive into a 20-bit dot product
module muladd_dot_seq #(
  parameter int VEC_LEN = 8,
  parameter int MAC_LAT = 0
) (
  input  logic        CLK,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        in_last,
  output logic [7:0]  mac_A,
  output logic [7:0]  mac_B,
  output logic [19:0] mac_C,
  input  logic [19:0] mac_Q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_data,
  output logic        out_ovf
);
  localparam logic [1:0] ACC  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [19:0] acc_q, acc_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        last_q, last_d;
  logic        step, end_c, p_neg, step_ovf;
  assign step     = (MAC_LAT == 0) ? (state_q == ACC && in_valid) : (state_q == WAIT);
  assign end_c    = ((MAC_LAT == 0) ? in_last : last_q) || cnt_q == 10'(VEC_LEN - 1);
  assign p_neg    = 1'((mac_Q - acc_q) >> 19);
  assign step_ovf = (acc_q[19] == p_neg) && (mac_Q[19] != acc_q[19]);
  assign in_ready  = state_q == ACC;
  assign out_valid = state_q == DONE;
  assign mac_A     = state_q == ACC ? in_a : state_q == WAIT ? a_q : 8'd0;
  assign mac_B     = state_q == ACC ? in_b : state_q == WAIT ? b_q : 8'd0;
  assign mac_C     = acc_q;
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  // next state: capture pair, fold Q into the accumulator, release result on handshake
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    if (MAC_LAT != 0 && state_q == ACC && in_valid) begin
      a_d     = in_a;
      b_d     = in_b;
      last_d  = in_last;
      state_d = WAIT;
    end
    if (step) begin
      acc_d   = mac_Q;
      cnt_d   = cnt_q + 10'd1;
      ovf_d   = ovf_q | step_ovf;
      state_d = end_c ? DONE : ACC;
    end
    if (state_q == DONE && out_ready) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = ACC;
    end
  end
  // state registers; clr discards any partial vector or pending result
  always_ff @(posedge CLK) begin
    if (clr) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_muladd_dot_seq.sv
// tb_muladd_dot_seq: directed checks of the sequencer against a behavioural MULADDA model
module tb_muladd_dot_seq;
  logic        CLK = 1'b0;
  logic        clr;
  logic [4:0]  in_valid;
  logic [4:0]  in_ready;
  logic [7:0]  in_a, in_b;
  logic        in_last;
  logic        out_ready;
  logic [4:0]  out_valid;
  logic [4:0]  out_ovf;
  logic [7:0]  mac_A [5];
  logic [7:0]  mac_B [5];
  logic [19:0] mac_C [5];
  logic [19:0] mac_Q [5];
  logic [19:0] out_data [5];
  int total = 0, passed = 0;
  always #5 CLK = ~CLK;
  for (genvar g = 0; g < 5; g++) begin : gen_dut
    localparam int VL = g == 0 ? 4 : g == 1 ? 8 : g == 2 ? 32 : g == 3 ? 31 : 4;
    localparam int LT = g == 4 ? 1 : 0;
    logic signed [7:0]  ar, br;
    logic signed [15:0] prod;
    // MULADDA model: optional A/B input registers, unregistered C, Q = C + A*B
    always @(posedge CLK) begin
      ar <= mac_A[g];
      br <= mac_B[g];
    end
    assign prod = LT != 0 ? ar * br : $signed(mac_A[g]) * $signed(mac_B[g]);
    assign mac_Q[g] = mac_C[g] + {{4{prod[15]}}, prod};
    muladd_dot_seq #(.VEC_LEN(VL), .MAC_LAT(LT)) dut (
      .CLK(CLK), .clr(clr), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mac_A(mac_A[g]), .mac_B(mac_B[g]), .mac_C(mac_C[g]), .mac_Q(mac_Q[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready),
      .out_data(out_data[g]), .out_ovf(out_ovf[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else passed++;
  endtask
  task automatic send(input int d, input int a, input int b, input bit l);
    int n = 0;
    in_valid[d] = 1'b1;
    in_a = 8'(a);
    in_b = 8'(b);
    in_last = l;
    while (!in_ready[d] && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("send_rdy", 32'(in_ready[d]), 1);
    @(negedge CLK);
    in_valid[d] = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic get(input int d, input logic [19:0] ed, input bit eo);
    int n = 0;
    while (!out_valid[d] && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("get_valid", 32'(out_valid[d]), 1);
    chk("get_data", 32'(out_data[d]), 32'(ed));
    chk("get_ovf", 32'(out_ovf[d]), 32'(eo));
    @(negedge CLK);
  endtask
  initial begin
    clr = 1'b1;
    in_valid = '0;
    in_a = '0;
    in_b = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    clr = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'h1f);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ovf", 32'(out_ovf), 0);
    chk("rst_macc", 32'(mac_C[0]), 0);
    chk("rst_data", 32'(out_data[0]), 0);
    send(0, 10, 10, 0);
    send(0, 10, -5, 0);
    send(0, -5, -5, 0);
    send(0, -1, -1, 0);
    chk("lat0_valid", 32'(out_valid[0]), 1);
    get(0, 20'd76, 0);
    send(1, -128, 127, 0);
    send(1, 3, 4, 1);
    get(1, 20'hFC08C, 0);
    send(1, -128, -128, 1);
    get(1, 20'd16384, 0);
    for (int i = 0; i < 32; i++) send(2, -128, -128, 0);
    get(2, 20'h80000, 1);
    for (int i = 0; i < 31; i++) send(3, -128, -128, 0);
    get(3, 20'd507904, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 1, 2, 0);
    in_valid[0] = 1'b1;
    in_a = 8'd3;
    in_b = 8'd3;
    in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 32'(in_ready[0]), 0);
      chk("bp_valid", 32'(out_valid[0]), 1);
      chk("bp_data", 32'(out_data[0]), 8);
      chk("bp_ovf", 32'(out_ovf[0]), 0);
      chk("bp_maca", 32'(mac_A[0]), 0);
      @(negedge CLK);
    end
    out_ready = 1'b1;
    @(negedge CLK);
    chk("bp_rel_ready", 32'(in_ready[0]), 1);
    chk("bp_rel_valid", 32'(out_valid[0]), 0);
    chk("bp_rel_macc", 32'(mac_C[0]), 0);
    @(negedge CLK);
    in_valid[0] = 1'b0;
    in_last = 1'b0;
    chk("bp_next_valid", 32'(out_valid[0]), 1);
    chk("bp_next_data", 32'(out_data[0]), 9);
    @(negedge CLK);
    send(0, 5, 5, 0);
    send(0, 5, 5, 0);
    chk("pre_clr_macc", 32'(mac_C[0]), 50);
    clr = 1'b1;
    @(negedge CLK);
    clr = 1'b0;
    chk("clr_macc", 32'(mac_C[0]), 0);
    chk("clr_valid", 32'(out_valid[0]), 0);
    chk("clr_ready", 32'(in_ready[0]), 1);
    for (int i = 0; i < 4; i++) send(0, 1, 1, 0);
    get(0, 20'd4, 0);
    in_valid[4] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = i == 0 ? 8'd10 : i == 1 ? 8'd10 : i == 2 ? 8'hFB : 8'hFF;
      in_b = i == 0 ? 8'd10 : i == 1 ? 8'hFB : i == 2 ? 8'hFB : 8'hFF;
      chk("l1_ready_hi", 32'(in_ready[4]), 1);
      @(negedge CLK);
      chk("l1_ready_lo", 32'(in_ready[4]), 0);
      if (i == 0) begin
        in_a = 8'h55;
        chk("l1_hold_a", 32'(mac_A[4]), 10);
      end
      @(negedge CLK);
    end
    in_valid[4] = 1'b0;
    chk("l1_valid", 32'(out_valid[4]), 1);
    chk("l1_data", 32'(out_data[4]), 76);
    chk("l1_ovf", 32'(out_ovf[4]), 0);
    @(negedge CLK);
    chk("l1_clear", 32'(out_valid[4]), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
